// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline sequencer for the five-stage MIPS core.
//
// Merges ID/EX/MEM stall requests into a per-stage hold vector, tracks
// multi-cycle divide waits, and sequences exception / ERET redirection
// through a FLUSH cycle followed by a QUIET drain cycle. Also produces the
// one-cycle IF/ID squash pulse that follows a taken branch.
//
// Optional feature: define PIPE_CTRL_WATCHDOG_EN to build a stall
// watchdog that raises a sticky wdog_err and forces a redirect to
// EXC_VECTOR once the PC has been held for WDOG_LIMIT consecutive cycles.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   stallreq_id/ex/mem  stage stall requests
//   excepttype_i    committed exception code (0 = none)
//   cp0_epc_i       EPC used as the ERET target
//   bflag_i         branch/jump taken in ID
//   div_start_i     divider accepted an operation
//   div_ready_i     divider result valid
//   stall[5:0]      hold vector {WB,MEM,EX,ID,IF,PC}
//   flush, new_pc   pipeline clear and redirect target (FLUSH state only)
//   div_cancel      abort the in-flight divide
//   squash_if       zero the IF/ID register
//   div_busy        divide wait in progress
//   wdog_err        sticky watchdog fault (0 without the watchdog)
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
    parameter int          WDOG_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        bflag_i,
    input  logic        div_start_i,
    input  logic        div_ready_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        div_cancel,
    output logic        squash_if,
    output logic        div_busy,
    output logic        wdog_err
);

    typedef enum logic [1:0] {RUN, DIVWAIT, FLUSH, QUIET} state_t;

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        div_cancel_q, div_cancel_d;
    logic        squash_q, squash_d;
    logic        div_busy_q, div_busy_d;
    logic        exc_any;
    logic        wdog_trip;

    // Hold-vector selection, highest priority first.
    function automatic logic [5:0] stall_sel(input state_t s, input logic exc,
                                             input logic id, input logic ex,
                                             input logic mem, input logic dr);
        logic [5:0] v;
        if (s == FLUSH || s == QUIET || exc) v = 6'b000000;
        else if (s == DIVWAIT && !dr)        v = 6'b001111;
        else if (mem)                        v = 6'b011111;
        else if (ex)                         v = 6'b001111;
        else if (id)                         v = 6'b000111;
        else                                 v = 6'b000000;
        return v;
    endfunction

`ifdef PIPE_CTRL_WATCHDOG_EN
    localparam int CW = $clog2(WDOG_LIMIT + 1);
    logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          wdog_err_q, wdog_err_d;

    // A saturated counter acts as a synthetic exception for one cycle;
    // that cycle drops stall[0], which clears the counter again.
    assign wdog_trip = (wdog_cnt_q == CW'(WDOG_LIMIT));

    always_comb begin
        wdog_cnt_d = '0;
        if (stall[0])
            wdog_cnt_d = (wdog_cnt_q == CW'(WDOG_LIMIT)) ? wdog_cnt_q : wdog_cnt_q + 1'b1;
        wdog_err_d = wdog_err_q | (wdog_cnt_d == CW'(WDOG_LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    logic wdog_unused;
    assign wdog_unused = (WDOG_LIMIT == 0);
    assign wdog_trip   = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    assign exc_any = (excepttype_i != 32'h0) || wdog_trip;
    assign stall   = stall_sel(state_q, exc_any, stallreq_id, stallreq_ex,
                               stallreq_mem, div_ready_i);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (exc_any)          state_d = FLUSH;
                else if (div_start_i) state_d = DIVWAIT;
            end
            DIVWAIT: begin
                if (exc_any)          state_d = FLUSH;
                else if (div_ready_i) state_d = RUN;
            end
            FLUSH:   state_d = QUIET;
            default: state_d = RUN;
        endcase

        // Outputs are registered views of the next state, so they line up
        // exactly with the cycle spent in that state.
        flush_d      = (state_d == FLUSH);
        div_cancel_d = (state_d == FLUSH) && (state_q == DIVWAIT);
        div_busy_d   = (state_d == DIVWAIT);
        new_pc_d     = 32'h0;
        if (state_d == FLUSH)
            new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        // A taken branch in the same cycle as an exception is discarded.
        squash_d     = bflag_i && (state_d == RUN || state_d == DIVWAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            flush_q      <= 1'b0;
            new_pc_q     <= 32'h0;
            div_cancel_q <= 1'b0;
            squash_q     <= 1'b0;
            div_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_q      <= flush_d;
            new_pc_q     <= new_pc_d;
            div_cancel_q <= div_cancel_d;
            squash_q     <= squash_d;
            div_busy_q   <= div_busy_d;
        end
    end

    assign flush      = flush_q;
    assign new_pc     = new_pc_q;
    assign div_cancel = div_cancel_q;
    assign squash_if  = squash_q;
    assign div_busy   = div_busy_q;

endmodule
